apb_cmd_sequencer: RTL

- Drains the Wishbone-side command buffer and executes each entry as one APB transfer.
- Pushes one response word per command into the response buffer.
- Sits between the two buffer instances inside the wb2apb bridge and is the APB master.
- Processes one transfer at a time, in order; no pipelining across commands.

---
 rtl/apb_cmd_sequencer_if.sv | 24 ++
 rtl/apb_cmd_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/apb_cmd_sequencer_if.sv
// APB bus bundle between the command sequencer (master) and the APB fabric (slave).
interface apb_cmd_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, pwrite, pwdata, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, pwdata, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: pops one command at a time from the command buffer, runs it
// as a single APB transfer and pushes one {err, rdata} word to the response buffer.
// Optional feature macro: APB_CMD_SEQ_TIMEOUT_EN aborts an ACCESS phase that has
// waited TIMEOUT_CYCLES cycles without pready, answering with err=1, rdata=0.
module apb_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0] cmd_dout,
  input  logic                           cmd_empty,
  output logic                           cmd_read_en,
  output logic [DATA_WIDTH:0]            rsp_din,
  output logic                           rsp_din_valid,
  input  logic                           rsp_full,
  apb_cmd_sequencer_if.master            apb,
  output logic                           busy,
  output logic [15:0]                    xfer_count
);

  localparam int unsigned CNT_W = 16;

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic                  write_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  err_r;
  logic                  psel_c;
  logic                  penable_c;
  logic                  timeout_c;

`ifdef APB_CMD_SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q;

  // Expiry fires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout_c = (state_q == ACCESS) && !apb.pready &&
                     (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Counts ACCESS cycles spent without pready; cleared in SETUP, i.e. on ACCESS entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else if (state_q == SETUP) begin
      wait_q <= '0;
    end else if ((state_q == ACCESS) && !apb.pready) begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the buffer strobes and APB phase decode.
  always_comb begin
    state_d       = state_q;
    cmd_read_en   = 1'b0;
    rsp_din_valid = 1'b0;
    psel_c        = 1'b0;
    penable_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cmd_empty) begin
          cmd_read_en = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        state_d = SETUP;
      end
      SETUP: begin
        psel_c  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
        if (apb.pready || timeout_c) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (!rsp_full) begin
          rsp_din_valid = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command latch, response capture and completed-response counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_r    <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
      xfer_count <= '0;
    end else begin
      if (state_q == FETCH) begin
        {write_r, addr_r, wdata_r} <= cmd_dout;
      end
      if ((state_q == ACCESS) && apb.pready) begin
        rdata_r <= write_r ? '0 : apb.prdata;
        err_r   <= apb.pslverr;
      end else if (timeout_c) begin
        rdata_r <= '0;
        err_r   <= 1'b1;
      end
      if (rsp_din_valid) begin
        xfer_count <= xfer_count + CNT_W'(1);
      end
    end
  end

  assign apb.psel    = psel_c;
  assign apb.penable = penable_c;
  assign apb.paddr   = addr_r;
  assign apb.pwrite  = write_r;
  assign apb.pwdata  = wdata_r;
  assign rsp_din     = {err_r, rdata_r};
  assign busy        = (state_q != IDLE);

endmodule
